// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle LEGv8 core.
// Gates instruction commit through CPU_CE and supports free-run, single-step,
// run-N, PC breakpoints and halt-instruction detection. It also counts
// committed instructions.
//
// Command handshake: CMD_READY is tied high. A command transfers on every
// rising CLOCK edge where CMD_VALID is high. There is no backpressure, and
// nothing is queued.
module cpu_run_ctrl #(
    parameter int                PC_W    = 64,
    parameter int                INSN_W  = 32,
    parameter int                CYC_W   = 32,
    parameter int                NUM_BP  = 4,
    parameter logic [INSN_W-1:0] HALT_OP = 32'h14000000
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_OP,
    input  logic [CYC_W-1:0]         CMD_COUNT,
    input  logic [NUM_BP-1:0]        BP_EN,
    input  logic [NUM_BP*PC_W-1:0]   BP_ADDR,
    input  logic [PC_W-1:0]          PC,
    input  logic [INSN_W-1:0]        INSTRUCTION,
    output logic                     CPU_CE,
    output logic [1:0]               STATE,
    output logic [2:0]               HALT_CAUSE,
    output logic [2:0]               BP_IDX,
    output logic [CYC_W-1:0]         CYCLE_COUNT,
    output logic                     DONE,
    output logic                     CMD_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COUNT  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_RUN_N = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_STOP  = 3'd1;
    localparam logic [2:0] CAUSE_COUNT = 3'd2;
    localparam logic [2:0] CAUSE_BP    = 3'd3;
    localparam logic [2:0] CAUSE_HALT  = 3'd4;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] remaining_q, remaining_d;
    logic [CYC_W-1:0] count_q, count_d;
    logic             skip_bp_q, skip_bp_d;
    logic [2:0]       cause_q, cause_d;
    logic [2:0]       bp_idx_q, bp_idx_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;

    logic             bp_hit;
    logic [2:0]       bp_hit_idx;
    logic             active;
    logic [2:0]       stop_cause;
    logic             cpu_ce;

    // Breakpoint match. Scan from the top index down, so the lowest matching index wins.
    always_comb begin
        bp_hit     = 1'b0;
        bp_hit_idx = 3'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (BP_EN[i] && (BP_ADDR[i*PC_W +: PC_W] == PC)) begin
                bp_hit     = 1'b1;
                bp_hit_idx = 3'(i);
            end
        end
    end

    // Next state, commit gating and halt-cause selection. The stop priority is
    // STOP > HALT_INSN > BREAKPOINT > COUNT.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        skip_bp_d   = skip_bp_q;
        cause_d     = cause_q;
        bp_idx_d    = bp_idx_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        stop_cause  = CAUSE_NONE;
        cpu_ce      = 1'b0;
        active      = (state_q == ST_RUN) || (state_q == ST_COUNT);

        if (active) begin
            if (CMD_VALID && (CMD_OP == OP_STOP))
                stop_cause = CAUSE_STOP;
            else if (INSTRUCTION == HALT_OP)
                stop_cause = CAUSE_HALT;
            else if (bp_hit && !skip_bp_q)
                stop_cause = CAUSE_BP;
            else if ((state_q == ST_COUNT) && (remaining_q == '0))
                stop_cause = CAUSE_COUNT;

            if (stop_cause != CAUSE_NONE) begin
                state_d = ST_HALTED;
                cause_d = stop_cause;
                done_d  = 1'b1;
                if (stop_cause == CAUSE_BP)
                    bp_idx_d = bp_hit_idx;
            end else begin
                // The CPU commits on this edge.
                cpu_ce    = 1'b1;
                skip_bp_d = 1'b0;
                if (count_q != '1)
                    count_d = count_q + 1'b1;
                if (state_q == ST_COUNT)
                    remaining_d = remaining_q - 1'b1;
            end

            // Run commands are not accepted while the core is running.
            if (CMD_VALID && (CMD_OP != OP_STOP))
                cmd_err_d = 1'b1;
        end else if (CMD_VALID && (CMD_OP != OP_STOP)) begin
            // Any run command clears the previous halt reason. It also arms
            // skip_bp, so the core can leave a breakpoint PC without
            // hitting that breakpoint again.
            skip_bp_d = 1'b1;
            cause_d   = CAUSE_NONE;
            bp_idx_d  = 3'd0;
            case (CMD_OP)
                OP_RUN: state_d = ST_RUN;
                OP_STEP: begin
                    state_d     = ST_COUNT;
                    remaining_d = CYC_W'(1);
                end
                default: begin
                    state_d     = ST_COUNT;
                    remaining_d = CMD_COUNT;
                end
            endcase
        end
    end

    // State and status registers, cleared asynchronously by reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            skip_bp_q   <= 1'b0;
            cause_q     <= CAUSE_NONE;
            bp_idx_q    <= 3'd0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            skip_bp_q   <= skip_bp_d;
            cause_q     <= cause_d;
            bp_idx_q    <= bp_idx_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign CMD_READY   = 1'b1;
    assign CPU_CE      = cpu_ce;
    assign STATE       = state_q;
    assign HALT_CAUSE  = cause_q;
    assign BP_IDX      = bp_idx_q;
    assign CYCLE_COUNT = count_q;
    assign DONE        = done_q;
    assign CMD_ERR     = cmd_err_q;

endmodule
